// File: rtl/xor_chain_checker.sv
// Stimulus/response checker for a chain of 2-bit mod-4 incrementer pairs: sweeps a vector set,
// lets each vector settle, then compares chain_out against the closed-form per-pair offset.
module xor_chain_checker #(
  parameter int IO_PAIRS = 1,
  parameter int DEPTH    = 1,
  parameter int SETTLE   = 2,
  parameter int NUM_VECS = 16,
  parameter int ERR_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [2*IO_PAIRS-1:0] chain_in,
  input  logic [2*IO_PAIRS-1:0] chain_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [15:0]           first_err,
  output logic [15:0]           vec_idx
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // DRIVE | vector held on chain_in while the settle counter runs down
  // CHECK | single-cycle compare of chain_out against the expected value
  // DONE  | results frozen until the next start

  localparam int W    = 2 * IO_PAIRS;
  localparam int REPS = (W + 15) / 16;
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0]       OFFSET      = 2'(DEPTH % 4);
  localparam logic [15:0]      LAST_IDX    = 16'(NUM_VECS - 1);
  localparam logic [15:0]      NO_ERR      = 16'hFFFF;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} stateT;

  stateT             state;
  stateT             stateNext;
  logic [W-1:0]      chainInNext;
  logic [W-1:0]      expVec;
  logic [SW-1:0]     settleCnt;
  logic [SW-1:0]     settleNext;
  logic [15:0]       vecIdxNext;
  logic [15:0]       firstErrNext;
  logic [ERR_W-1:0]  errNext;
  logic              doneNext;
  logic              passNext;
  logic              mismatch;

  // Vector k is the 16-bit index replicated across the bus, truncated to W bits.
  function automatic logic [W-1:0] vecOf(input logic [15:0] k);
    logic [16*REPS-1:0] rep;
    rep = {REPS{k}};
    return rep[W-1:0];
  endfunction

  // Each pair advances by DEPTH mod 4; the 2-bit add drops the carry so pairs stay independent.
  genvar p;
  for (p = 0; p < IO_PAIRS; p++) begin : gExp
    assign expVec[2*p +: 2] = chain_in[2*p +: 2] + OFFSET;
  end

  // Case inequality so an unknown chain output is counted as a failure.
  assign mismatch = (chain_out !== expVec);
  assign busy     = (state == DRIVE) || (state == CHECK);

  always_comb begin
    stateNext    = state;
    chainInNext  = chain_in;
    settleNext   = settleCnt;
    vecIdxNext   = vec_idx;
    errNext      = err_count;
    firstErrNext = first_err;
    doneNext     = done;
    passNext     = pass;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext    = DRIVE;
          chainInNext  = vecOf(16'd0);
          settleNext   = SETTLE_LOAD;
          vecIdxNext   = 16'd0;
          errNext      = '0;
          firstErrNext = NO_ERR;
          doneNext     = 1'b0;
          passNext     = 1'b0;
        end
      end

      DRIVE: begin
        if (settleCnt == '0) begin
          stateNext = CHECK;
        end else begin
          settleNext = settleCnt - SW'(1);
        end
      end

      CHECK: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) begin
            errNext = err_count + ERR_W'(1);
          end
          if (first_err == NO_ERR) begin
            firstErrNext = vec_idx;
          end
        end

        if (vec_idx == LAST_IDX) begin
          stateNext = DONE;
          doneNext  = 1'b1;
          passNext  = (errNext == '0);
        end else begin
          stateNext   = DRIVE;
          vecIdxNext  = vec_idx + 16'd1;
          chainInNext = vecOf(vec_idx + 16'd1);
          settleNext  = SETTLE_LOAD;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chain_in  <= '0;
      settleCnt <= '0;
      vec_idx   <= 16'd0;
      err_count <= '0;
      first_err <= NO_ERR;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= stateNext;
      chain_in  <= chainInNext;
      settleCnt <= settleNext;
      vec_idx   <= vecIdxNext;
      err_count <= errNext;
      first_err <= firstErrNext;
      done      <= doneNext;
      pass      <= passNext;
    end
  end

endmodule

// File: tb/tb_xor_chain_checker.sv
// Bench for xor_chain_checker: several parameterisations, each driven by a behavioural chain
// model; expected results come from plain arithmetic over the vector set.
module tb_xor_chain_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-pair (pair + depth) mod 4 using integer arithmetic.
  function automatic logic [31:0] modelOut(input logic [31:0] v, input int pairs, input int depth);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < pairs; i++) begin
      int field;
      field = int'((v >> (2 * i)) & 32'd3);
      r = r | (32'((field + depth) % 4) << (2 * i));
    end
    return r;
  endfunction

  // Vector k: bit i of the bus is bit (i mod 16) of k.
  function automatic logic [31:0] vecModel(input int k, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (((k >> (i % 16)) & 1) != 0) r = r | (32'd1 << i);
    end
    return r;
  endfunction

  // A: T1/T6 configuration
  logic        startA = 1'b0;
  logic [1:0]  chainInA, chainOutA;
  logic        busyA, doneA, passA;
  logic [15:0] errA, firstA, vecA;
  xor_chain_checker #(.IO_PAIRS(1), .DEPTH(1), .SETTLE(2), .NUM_VECS(4), .ERR_W(16)) dutA (
    .clk(clk), .rst(rst), .start(startA), .chain_in(chainInA), .chain_out(chainOutA),
    .busy(busyA), .done(doneA), .pass(passA), .err_count(errA), .first_err(firstA), .vec_idx(vecA));
  always_comb chainOutA = 2'(modelOut(32'(chainInA), 1, 1));

  // B: identity chain (DEPTH multiple of 4)
  logic        startB = 1'b0;
  logic [7:0]  chainInB, chainOutB;
  logic        busyB, doneB, passB;
  logic [15:0] errB, firstB, vecB;
  xor_chain_checker #(.IO_PAIRS(4), .DEPTH(4), .SETTLE(2), .NUM_VECS(256), .ERR_W(16)) dutB (
    .clk(clk), .rst(rst), .start(startB), .chain_in(chainInB), .chain_out(chainOutB),
    .busy(busyB), .done(doneB), .pass(passB), .err_count(errB), .first_err(firstB), .vec_idx(vecB));
  always_comb chainOutB = 8'(modelOut(32'(chainInB), 4, 4));

  // C: fault-injection chain with selectable behaviour
  logic        startC = 1'b0;
  logic [3:0]  chainInC, chainOutC, idealC;
  logic        busyC, doneC, passC;
  logic [15:0] errC, firstC, vecC;
  int          modeC = 0;
  int          xIdxC = 0;
  logic        inCheckC = 1'b0;
  xor_chain_checker #(.IO_PAIRS(2), .DEPTH(3), .SETTLE(2), .NUM_VECS(16), .ERR_W(16)) dutC (
    .clk(clk), .rst(rst), .start(startC), .chain_in(chainInC), .chain_out(chainOutC),
    .busy(busyC), .done(doneC), .pass(passC), .err_count(errC), .first_err(firstC), .vec_idx(vecC));
  always_comb begin
    idealC = 4'(modelOut(32'(chainInC), 2, 3));
    case (modeC)
      1: chainOutC = {idealC[3:1], 1'b0};
      2: chainOutC = (int'(chainInC) == xIdxC) ? 4'bxxxx : idealC;
      3: chainOutC = inCheckC ? idealC : ~idealC;
      default: chainOutC = idealC;
    endcase
  end

  // D: narrow error counter, always-wrong chain
  logic        startD = 1'b0;
  logic [1:0]  chainInD, chainOutD;
  logic        busyD, doneD, passD;
  logic [1:0]  errD;
  logic [15:0] firstD, vecD;
  xor_chain_checker #(.IO_PAIRS(1), .DEPTH(1), .SETTLE(2), .NUM_VECS(10), .ERR_W(2)) dutD (
    .clk(clk), .rst(rst), .start(startD), .chain_in(chainInD), .chain_out(chainOutD),
    .busy(busyD), .done(doneD), .pass(passD), .err_count(errD), .first_err(firstD), .vec_idx(vecD));
  always_comb chainOutD = ~2'(modelOut(32'(chainInD), 1, 1));

  // E: wide bus (replication wraps), SETTLE=1, random per-vector corruption
  logic        startE = 1'b0;
  logic [17:0] chainInE, chainOutE;
  logic        busyE, doneE, passE;
  logic [15:0] errE, firstE, vecE;
  logic [17:0] corruptE [0:63];
  xor_chain_checker #(.IO_PAIRS(9), .DEPTH(6), .SETTLE(1), .NUM_VECS(40), .ERR_W(16)) dutE (
    .clk(clk), .rst(rst), .start(startE), .chain_in(chainInE), .chain_out(chainOutE),
    .busy(busyE), .done(doneE), .pass(passE), .err_count(errE), .first_err(firstE), .vec_idx(vecE));
  always_comb chainOutE = 18'(modelOut(32'(chainInE), 9, 6)) ^ corruptE[chainInE[5:0]];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({chainInA, busyA, doneA, passA, errA, firstA, vecA} !== {2'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0}) begin
      errors++;
      $display("FAIL reset_A: got %h required %h", {chainInA, busyA, doneA, passA, errA, firstA, vecA},
               {2'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0});
    end
    checks++;
    if ({chainInC, busyC, doneC, passC, errC, firstC, vecC} !== {4'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0}) begin
      errors++;
      $display("FAIL reset_C: got %h required %h", {chainInC, busyC, doneC, passC, errC, firstC, vecC},
               {4'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0});
    end
    checks++;
    if ({chainInD, busyD, doneD, passD, errD, firstD, vecD} !== {2'b0, 3'b0, 2'b0, 16'hFFFF, 16'h0}) begin
      errors++;
      $display("FAIL reset_D: got %h required %h", {chainInD, busyD, doneD, passD, errD, firstD, vecD},
               {2'b0, 3'b0, 2'b0, 16'hFFFF, 16'h0});
    end
    checks++;
    if ({chainInE, busyE, doneE, passE, errE, firstE, vecE} !== {18'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0}) begin
      errors++;
      $display("FAIL reset_E: got %h required %h", {chainInE, busyE, doneE, passE, errE, firstE, vecE},
               {18'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0});
    end
    checks++;
    if ({chainInB, busyB, doneB, passB, errB, firstB, vecB} !== {8'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0}) begin
      errors++;
      $display("FAIL reset_B: got %h required %h", {chainInB, busyB, doneB, passB, errB, firstB, vecB},
               {8'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busyA, doneA} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start: got busy/done %b required 00", {busyA, doneA});
    end
  endtask

  // Runs instance A once; optional start pulses land in DRIVE, CHECK and the last CHECK.
  task automatic runA(input bit pulses, input string name);
    startA = 1'b1;
    tick();
    for (int e = 0; e < 12; e++) begin
      checks++;
      if ({chainInA, vecA, busyA, doneA} !== {2'(e / 3), 16'(e / 3), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s_step%0d: got in/idx/busy/done %h required %h", name, e,
                 {chainInA, vecA, busyA, doneA}, {2'(e / 3), 16'(e / 3), 1'b1, 1'b0});
      end
      startA = pulses && (e == 1 || e == 2 || e == 11);
      tick();
    end
    startA = 1'b0;
    checks++;
    if ({doneA, busyA, passA, errA, firstA} !== {3'b101, 16'h0, 16'hFFFF}) begin
      errors++;
      $display("FAIL %s_result: got done/busy/pass/err/first %h required %h", name,
               {doneA, busyA, passA, errA, firstA}, {3'b101, 16'h0, 16'hFFFF});
    end
    tick();
    tick();
    checks++;
    if ({doneA, chainInA} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL %s_hold: got done/chain_in %h required %h", name, {doneA, chainInA}, {1'b1, 2'd3});
    end
  endtask

  task automatic test_basic();
    runA(1'b0, "basic");
  endtask

  task automatic test_start_ignored();
    runA(1'b1, "start_ignored");
  endtask

  task automatic test_identity();
    int bad;
    bad = 0;
    startB = 1'b1;
    tick();
    startB = 1'b0;
    for (int e = 0; e < 768; e++) begin
      if ({chainInB, vecB, busyB, doneB} !== {8'(vecModel(e / 3, 8)), 16'(e / 3), 1'b1, 1'b0}) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL identity_sweep: got %0d bad steps required 0", bad);
    end
    checks++;
    if ({doneB, passB, errB, firstB} !== {2'b11, 16'h0, 16'hFFFF}) begin
      errors++;
      $display("FAIL identity_result: got %h required %h", {doneB, passB, errB, firstB}, {2'b11, 16'h0, 16'hFFFF});
    end
  endtask

  // Runs instance C for all 16 vectors, toggling inCheckC in the expected CHECK cycles.
  task automatic runC(input int expErr, input int expFirst, input string name);
    startC = 1'b1;
    tick();
    startC = 1'b0;
    for (int e = 0; e < 48; e++) begin
      checks++;
      if ({busyC, doneC, vecC} !== {2'b10, 16'(e / 3)}) begin
        errors++;
        $display("FAIL %s_step%0d: got busy/done/idx %h required %h", name, e,
                 {busyC, doneC, vecC}, {2'b10, 16'(e / 3)});
      end
      inCheckC = (e % 3 == 2);
      tick();
    end
    inCheckC = 1'b0;
    checks++;
    if ({doneC, passC, errC, firstC} !== {1'b1, expErr == 0, 16'(expErr), 16'(expFirst)}) begin
      errors++;
      $display("FAIL %s_result: got done/pass/err/first %h required %h", name,
               {doneC, passC, errC, firstC}, {1'b1, expErr == 0, 16'(expErr), 16'(expFirst)});
    end
  endtask

  task automatic test_stuck();
    int expErr;
    int expFirst;
    expErr = 0;
    expFirst = 65535;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] ideal;
      ideal = modelOut(vecModel(k, 4), 2, 3);
      if ((ideal & ~32'd1) != ideal) begin
        expErr++;
        if (expFirst == 65535) expFirst = k;
      end
    end
    modeC = 1;
    runC(expErr, expFirst, "stuck");
  endtask

  task automatic test_xcheck();
    xIdxC = int'($urandom_range(0, 14));
    if (xIdxC >= 5) xIdxC++;
    modeC = 2;
    runC(1, xIdxC, "xcheck");
  endtask

  task automatic test_saturate();
    int count;
    int first;
    count = 0;
    first = 65535;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] ideal;
      ideal = modelOut(vecModel(k, 2), 1, 1);
      if (((~ideal) & 32'd3) != ideal) begin
        count++;
        if (first == 65535) first = k;
      end
    end
    if (count > 3) count = 3;
    startD = 1'b1;
    tick();
    startD = 1'b0;
    for (int e = 0; e < 30; e++) tick();
    checks++;
    if ({doneD, passD, errD, firstD, vecD} !== {2'b10, 2'(count), 16'(first), 16'd9}) begin
      errors++;
      $display("FAIL saturate: got done/pass/err/first/idx %h required %h",
               {doneD, passD, errD, firstD, vecD}, {2'b10, 2'(count), 16'(first), 16'd9});
    end
  endtask

  task automatic test_abort();
    int partial;
    partial = 0;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] ideal;
      ideal = modelOut(vecModel(k, 4), 2, 3);
      if (ideal[0]) partial++;
    end
    modeC = 1;
    startC = 1'b1;
    tick();
    startC = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    checks++;
    if ({busyC, vecC, errC, firstC} !== {1'b1, 16'd5, 16'(partial), 16'd0}) begin
      errors++;
      $display("FAIL abort_before: got busy/idx/err/first %h required %h",
               {busyC, vecC, errC, firstC}, {1'b1, 16'd5, 16'(partial), 16'd0});
    end
    rst = 1'b1;
    startC = 1'b1;
    tick();
    checks++;
    if ({chainInC, busyC, doneC, passC, errC, firstC, vecC} !== {4'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0}) begin
      errors++;
      $display("FAIL abort_reset: got %h required %h", {chainInC, busyC, doneC, passC, errC, firstC, vecC},
               {4'b0, 3'b0, 16'h0, 16'hFFFF, 16'h0});
    end
    rst = 1'b0;
    startC = 1'b0;
    tick();
    checks++;
    if ({busyC, doneC} !== 2'b00) begin
      errors++;
      $display("FAIL rst_beats_start: got busy/done %b required 00", {busyC, doneC});
    end
    modeC = 3;
    runC(0, 65535, "after_abort");
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      int expErr;
      int expFirst;
      int bad;
      expErr = 0;
      expFirst = 65535;
      bad = 0;
      for (int k = 0; k < 64; k++) corruptE[k] = '0;
      if (run > 0) begin
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 3) == 0) corruptE[k] = 18'($urandom) | (18'd1 << $urandom_range(0, 17));
        end
      end
      for (int k = 0; k < 40; k++) begin
        if (corruptE[k] != '0) begin
          expErr++;
          if (expFirst == 65535) expFirst = k;
        end
      end
      startE = 1'b1;
      tick();
      for (int e = 0; e < 80; e++) begin
        if ({chainInE, vecE, busyE, doneE} !== {18'(vecModel(e / 2, 18)), 16'(e / 2), 1'b1, 1'b0}) bad++;
        startE = ($urandom_range(0, 7) == 0);
        tick();
      end
      startE = 1'b0;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_run%0d_sweep: got %0d bad steps required 0", run, bad);
      end
      checks++;
      if ({doneE, passE, errE, firstE} !== {1'b1, expErr == 0, 16'(expErr), 16'(expFirst)}) begin
        errors++;
        $display("FAIL random_run%0d_result: got done/pass/err/first %h required %h", run,
                 {doneE, passE, errE, firstE}, {1'b1, expErr == 0, 16'(expErr), 16'(expFirst)});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) corruptE[k] = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_start_ignored();
    test_identity();
    test_stuck();
    test_xcheck();
    test_saturate();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
